// File: rtl/spi_slave_regbank_if.sv
// SPI pins plus register-bank write/read bus of spi_slave_regbank, grouped per direction.
interface spi_slave_regbank_if #(
  parameter int DW = 8,
  parameter int AW = 7
);
  logic          spics_n;
  logic          spick;
  logic          spido;
  logic          spidi;
  logic [DW-1:0] status_in;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_stb;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          xfer_end;
  logic          xfer_err;

  modport slave (
    input  spics_n, spick, spido, status_in, rd_data,
    output spidi, wr_addr, wr_data, wr_stb, rd_addr, xfer_end, xfer_err
  );

  modport master (
    output spics_n, spick, spido, status_in, rd_data,
    input  spidi, wr_addr, wr_data, wr_stb, rd_addr, xfer_end, xfer_err
  );
endinterface

// File: rtl/spi_slave_regbank.sv
// SPI slave register bank: address word while CS high, write/read data words while CS low; watchdog via SPI_SLAVE_REGBANK_WDOG_EN.
// Pins act SYNC_STAGES+1 fclk after they change, wr_stb the cycle after a word's last bit; no backpressure, the SPI master paces all traffic.
module spi_slave_regbank #(
  parameter int DW          = 8,
  parameter int AW          = 7,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2,
  parameter int WDOG_CYC    = 4096
) (
  input  logic               fclk,
  input  logic               rst_n,
  spi_slave_regbank_if.slave bus
);
  localparam int BCW = $clog2(DW);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DW - 1);

  // Elaboration-time range guard: an out-of-range setting leaves this named block in the hierarchy.
  if (DW < 4 || SYNC_STAGES < 2 || WDOG_CYC < 2 || WDOG_CYC > 65536) begin : g_param_out_of_range
  end

  logic [SYNC_STAGES:0] cs_sync, ck_sync, do_sync;
  logic                 scs, scs_fall, scs_rise, sck_rise, sdo;

  logic [AW:0]     areg, areg_nxt;
  logic [DW-1:0]   shift_in, sin_nxt;
  logic [DW-1:0]   shift_out, sout_nxt;
  logic [BCW-1:0]  bitcnt;
  logic [AW-1:0]   cur_addr, rd_addr_q, wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic            ainc, load_pend, wr_stb_q, xfer_end_q, wdog_fire;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync <= '1;
      ck_sync <= '0;
      do_sync <= '0;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-1:0], bus.spics_n};
      ck_sync <= {ck_sync[SYNC_STAGES-1:0], bus.spick};
      do_sync <= {do_sync[SYNC_STAGES-1:0], bus.spido};
    end
  end

  assign scs      = cs_sync[SYNC_STAGES-1];
  assign scs_fall = cs_sync[SYNC_STAGES] & ~scs;
  assign scs_rise = ~cs_sync[SYNC_STAGES] & scs;
  assign sck_rise = ~ck_sync[SYNC_STAGES] & ck_sync[SYNC_STAGES-1];
  // Data taken from the edge-flop stage: the value held just before SCK rose.
  assign sdo      = do_sync[SYNC_STAGES];

  if (LSB_FIRST) begin : g_lsb
    assign areg_nxt  = {sdo, areg[AW:1]};
    assign sin_nxt   = {sdo, shift_in[DW-1:1]};
    assign sout_nxt  = {1'b0, shift_out[DW-1:1]};
    assign bus.spidi = shift_out[0];
  end else begin : g_msb
    assign areg_nxt  = {areg[AW-1:0], sdo};
    assign sin_nxt   = {shift_in[DW-2:0], sdo};
    assign sout_nxt  = {shift_out[DW-2:0], 1'b0};
    assign bus.spidi = shift_out[DW-1];
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      areg       <= '0;
      shift_in   <= '0;
      shift_out  <= '0;
      bitcnt     <= '0;
      cur_addr   <= '0;
      ainc       <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      load_pend  <= 1'b0;
      wr_stb_q   <= 1'b0;
      xfer_end_q <= 1'b0;
    end else begin
      wr_stb_q   <= 1'b0;
      xfer_end_q <= 1'b0;
      if (load_pend) begin
        shift_out <= bus.rd_data;
        load_pend <= 1'b0;
      end
      // CS edges take precedence; an SCK edge landing in the same cycle is dropped.
      if (scs_fall) begin
        cur_addr  <= areg[AW-1:0];
        ainc      <= areg[AW];
        rd_addr_q <= areg[AW-1:0];
        bitcnt    <= '0;
        load_pend <= 1'b1;
      end else if (scs_rise) begin
        xfer_end_q <= 1'b1;
        shift_out  <= bus.status_in;
        bitcnt     <= '0;
        areg       <= '0;
        load_pend  <= 1'b0;
      end else if (sck_rise) begin
        shift_out <= sout_nxt;
        if (scs) begin
          areg <= areg_nxt;
        end else begin
          shift_in <= sin_nxt;
          if (bitcnt == LAST_BIT) begin
            bitcnt    <= '0;
            wr_stb_q  <= 1'b1;
            wr_data_q <= sin_nxt;
            wr_addr_q <= cur_addr;
            load_pend <= 1'b1;
            if (ainc) begin
              cur_addr  <= cur_addr + AW'(1);
              rd_addr_q <= cur_addr + AW'(1);
            end
          end else begin
            bitcnt <= bitcnt + BCW'(1);
          end
        end
      end else if (wdog_fire) begin
        bitcnt    <= '0;
        load_pend <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_REGBANK_WDOG_EN
  logic [15:0] wdog_cnt;
  logic        wdog_run, xfer_err_q;

  // Runs only mid-word with no SCK activity; any edge restarts the count.
  assign wdog_run  = ~scs & (bitcnt != '0) & ~sck_rise & ~scs_fall;
  assign wdog_fire = wdog_run & (wdog_cnt == 16'(WDOG_CYC - 1));

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt   <= '0;
      xfer_err_q <= 1'b0;
    end else begin
      xfer_err_q <= wdog_fire;
      if (!wdog_run || wdog_fire) wdog_cnt <= '0;
      else                        wdog_cnt <= wdog_cnt + 16'd1;
    end
  end

  assign bus.xfer_err = xfer_err_q;
`else
  assign wdog_fire    = 1'b0;
  assign bus.xfer_err = 1'b0;
`endif

  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_stb   = wr_stb_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.xfer_end = xfer_end_q;
endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed bench for spi_slave_regbank: an 8-bit LSB-first instance and a 16-bit MSB-first instance on shared SCK/MOSI.
module tb_spi_slave_regbank;
  localparam int HALF = 8;

  logic fclk  = 1'b0;
  logic rst_n = 1'b0;
  logic sck   = 1'b0;
  logic sdo   = 1'b0;
  logic cs0_n = 1'b1;
  logic cs1_n = 1'b1;

  always #5 fclk = ~fclk;

  spi_slave_regbank_if #(.DW(8),  .AW(7)) bus0 ();
  spi_slave_regbank_if #(.DW(16), .AW(7)) bus1 ();

  assign bus0.spics_n   = cs0_n;
  assign bus0.spick     = sck;
  assign bus0.spido     = sdo;
  assign bus0.status_in = 8'h5A;
  assign bus0.rd_data   = {1'b1, bus0.rd_addr};
  assign bus1.spics_n   = cs1_n;
  assign bus1.spick     = sck;
  assign bus1.spido     = sdo;
  assign bus1.status_in = 16'hC3A5;
  assign bus1.rd_data   = {9'h155, bus1.rd_addr};

  spi_slave_regbank #(.DW(8), .AW(7), .LSB_FIRST(1'b1), .SYNC_STAGES(2), .WDOG_CYC(64)) dut0 (
    .fclk (fclk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  spi_slave_regbank #(.DW(16), .AW(7), .LSB_FIRST(1'b0), .SYNC_STAGES(3), .WDOG_CYC(4096)) dut1 (
    .fclk (fclk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0]  wa0 [$];
  logic [7:0]  wd0 [$];
  logic [6:0]  wa1 [$];
  logic [15:0] wd1 [$];
  int xe0 = 0, xr0 = 0, xe1 = 0;

  always @(negedge fclk) begin
    if (bus0.wr_stb) begin
      wa0.push_back(bus0.wr_addr);
      wd0.push_back(bus0.wr_data);
    end
    if (bus1.wr_stb) begin
      wa1.push_back(bus1.wr_addr);
      wd1.push_back(bus1.wr_data);
    end
    if (bus0.xfer_end) xe0++;
    if (bus0.xfer_err) xr0++;
    if (bus1.xfer_end) xe1++;
  end

  task automatic clr();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    xe0 = 0; xr0 = 0; xe1 = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input bit sel1, input logic b, output logic rx);
    sdo = b;
    repeat (HALF) @(negedge fclk);
    rx  = sel1 ? bus1.spidi : bus0.spidi;
    sck = 1'b1;
    repeat (HALF) @(negedge fclk);
    sck = 1'b0;
  endtask

  // dut0 is LSB-first, dut1 MSB-first; rx is reassembled in the same bit order.
  task automatic spi_word(input bit sel1, input int n, input logic [15:0] val, output logic [15:0] rx);
    logic r;
    int   k;
    rx = '0;
    for (int i = 0; i < n; i++) begin
      k = sel1 ? (n - 1 - i) : i;
      spi_bit(sel1, val[k], r);
      rx[k] = r;
    end
  endtask

  task automatic cs_low(input bit sel1);
    if (sel1) cs1_n = 1'b0;
    else      cs0_n = 1'b0;
    repeat (10) @(negedge fclk);
  endtask

  task automatic cs_high(input bit sel1);
    repeat (4) @(negedge fclk);
    if (sel1) cs1_n = 1'b1;
    else      cs0_n = 1'b1;
    repeat (10) @(negedge fclk);
  endtask

  function automatic logic [31:0] outs0();
    return {6'd0, bus0.wr_addr, bus0.wr_data, bus0.wr_stb, bus0.rd_addr,
            bus0.xfer_end, bus0.xfer_err, bus0.spidi};
  endfunction

  function automatic logic [31:0] outs1();
    return {bus1.wr_addr, bus1.wr_data, bus1.wr_stb, bus1.rd_addr,
            bus1.xfer_end, bus1.xfer_err};
  endfunction

  typedef struct {
    logic [7:0] addr;
    int         nw;
    int         npart;
    logic [7:0] d   [3];
    logic [6:0] ea  [3];
    logic [7:0] erx [3];
    logic [7:0] estat;
  } vec_t;

  vec_t tv [7];

  initial begin : watchdog_timer
    #900us;
    $display("FAIL timeout: simulation still running at 900us, required finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] rx;

    tv[0] = '{addr:8'hA5, nw:3, npart:0, d:'{8'h11, 8'h22, 8'h33},
              ea:'{7'h25, 7'h26, 7'h27}, erx:'{8'hA5, 8'hA6, 8'hA7}, estat:8'h00};
    tv[1] = '{addr:8'hFF, nw:2, npart:0, d:'{8'h5C, 8'hC3, 8'h00},
              ea:'{7'h7F, 7'h00, 7'h00}, erx:'{8'hFF, 8'h80, 8'h00}, estat:8'h5A};
    tv[2] = '{addr:8'h7F, nw:2, npart:0, d:'{8'h01, 8'h80, 8'h00},
              ea:'{7'h7F, 7'h7F, 7'h00}, erx:'{8'hFF, 8'hFF, 8'h00}, estat:8'h5A};
    tv[3] = '{addr:8'h90, nw:2, npart:0, d:'{8'h3C, 8'hF0, 8'h00},
              ea:'{7'h10, 7'h11, 7'h00}, erx:'{8'h90, 8'h91, 8'h00}, estat:8'h5A};
    tv[4] = '{addr:8'h42, nw:0, npart:5, d:'{8'h00, 8'h00, 8'h00},
              ea:'{7'h00, 7'h00, 7'h00}, erx:'{8'h00, 8'h00, 8'h00}, estat:8'h5A};
    tv[5] = '{addr:8'h03, nw:1, npart:0, d:'{8'h6B, 8'h00, 8'h00},
              ea:'{7'h03, 7'h00, 7'h00}, erx:'{8'h83, 8'h00, 8'h00}, estat:8'h5A};
    tv[6] = '{addr:8'h55, nw:0, npart:0, d:'{8'h00, 8'h00, 8'h00},
              ea:'{7'h00, 7'h00, 7'h00}, erx:'{8'h00, 8'h00, 8'h00}, estat:8'h5A};

    repeat (4) @(negedge fclk);
    chk("reset outs dut0", outs0(), 32'h0);
    chk("reset outs dut1", outs1(), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge fclk);
    chk("idle outs dut0", outs0(), 32'h0);

    for (int v = 0; v < 7; v++) begin
      clr();
      spi_word(1'b0, 8, {8'h00, tv[v].addr}, rx);
      chk($sformatf("v%0d status", v), rx, {8'h00, tv[v].estat});
      cs_low(1'b0);
      for (int w = 0; w < tv[v].nw; w++) begin
        spi_word(1'b0, 8, {8'h00, tv[v].d[w]}, rx);
        chk($sformatf("v%0d rx%0d", v, w), rx, {8'h00, tv[v].erx[w]});
      end
      if (tv[v].npart > 0) spi_word(1'b0, tv[v].npart, 16'h001F, rx);
      cs_high(1'b0);
      chk($sformatf("v%0d writes", v), wa0.size(), tv[v].nw);
      for (int w = 0; w < tv[v].nw; w++) begin
        if (w < wa0.size()) begin
          chk($sformatf("v%0d wr_addr%0d", v, w), wa0[w], tv[v].ea[w]);
          chk($sformatf("v%0d wr_data%0d", v, w), wd0[w], tv[v].d[w]);
        end
      end
      chk($sformatf("v%0d xfer_end", v), xe0, 1);
      chk($sformatf("v%0d xfer_err", v), xr0, 0);
    end

    // 16 address-phase bits: status then zeros out, oldest 8 address bits discarded.
    clr();
    spi_word(1'b0, 16, 16'h8AFF, rx);
    chk("status tail", rx, 16'h005A);
    cs_low(1'b0);
    spi_word(1'b0, 8, 16'h00E7, rx);
    chk("long addr rx", rx, 16'h008A);
    cs_high(1'b0);
    chk("long addr writes", wa0.size(), 1);
    if (wa0.size() > 0) begin
      chk("long addr wr_addr", wa0[0], 7'h0A);
      chk("long addr wr_data", wd0[0], 8'hE7);
    end

    // 16-bit MSB-first instance: full word then a 9-bit partial.
    clr();
    spi_word(1'b1, 8, 16'h0085, rx);
    cs_low(1'b1);
    spi_word(1'b1, 16, 16'hBEEF, rx);
    chk("w16 rx0", rx, 16'hAA85);
    spi_word(1'b1, 9, 16'h01FF, rx);
    cs_high(1'b1);
    chk("w16 writes", wa1.size(), 1);
    if (wa1.size() > 0) begin
      chk("w16 wr_addr", wa1[0], 7'h05);
      chk("w16 wr_data", wd1[0], 16'hBEEF);
    end
    chk("w16 xfer_end", xe1, 1);

    clr();
    spi_word(1'b1, 8, 16'h0009, rx);
    chk("w16 status", rx, 16'h00C3);
    cs_low(1'b1);
    spi_word(1'b1, 16, 16'h1234, rx);
    chk("w16 noinc rx0", rx, 16'hAA89);
    spi_word(1'b1, 16, 16'h8001, rx);
    chk("w16 noinc rx1", rx, 16'hAA89);
    cs_high(1'b1);
    chk("w16 noinc writes", wa1.size(), 2);
    if (wa1.size() > 1) begin
      chk("w16 noinc addr0", wa1[0], 7'h09);
      chk("w16 noinc addr1", wa1[1], 7'h09);
      chk("w16 noinc data0", wd1[0], 16'h1234);
      chk("w16 noinc data1", wd1[1], 16'h8001);
    end

    // Reset in the middle of a burst.
    clr();
    spi_word(1'b0, 8, 16'h00A5, rx);
    cs_low(1'b0);
    spi_word(1'b0, 3, 16'h0005, rx);
    rst_n = 1'b0;
    cs0_n = 1'b1;
    repeat (3) @(negedge fclk);
    chk("midrst outs dut0", outs0(), 32'h0);
    chk("midrst outs dut1", outs1(), 32'h0);
    rst_n = 1'b1;
    repeat (40) @(negedge fclk);
    chk("postrst writes", wa0.size(), 0);
    chk("postrst xfer_end", xe0, 0);
    spi_word(1'b0, 8, 16'h0020, rx);
    cs_low(1'b0);
    spi_word(1'b0, 8, 16'h0077, rx);
    chk("postrst rx", rx, 16'h00A0);
    cs_high(1'b0);
    chk("postrst fresh writes", wa0.size(), 1);
    if (wa0.size() > 0) begin
      chk("postrst wr_addr", wa0[0], 7'h20);
      chk("postrst wr_data", wd0[0], 8'h77);
    end
    chk("postrst fresh xfer_end", xe0, 1);

    // Stalled partial word: 3 bits then a long idle with CS low.
    clr();
    spi_word(1'b0, 8, 16'h002A, rx);
    cs_low(1'b0);
    spi_word(1'b0, 3, 16'h0007, rx);
    repeat (100) @(negedge fclk);
`ifdef SPI_SLAVE_REGBANK_WDOG_EN
    chk("wdog xfer_err", xr0, 1);
    chk("wdog writes", wa0.size(), 0);
    spi_word(1'b0, 8, 16'h005E, rx);
    chk("wdog reload rx", rx, 16'h00AA);
    cs_high(1'b0);
    chk("wdog after writes", wa0.size(), 1);
    if (wa0.size() > 0) begin
      chk("wdog wr_addr", wa0[0], 7'h2A);
      chk("wdog wr_data", wd0[0], 8'h5E);
    end
`else
    chk("stall xfer_err", xr0, 0);
    chk("stall writes", wa0.size(), 0);
    cs_high(1'b0);
    chk("stall drop writes", wa0.size(), 0);
    chk("stall xfer_end", xe0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
